// File: rtl/operand_fetch_pkg.sv
// Shared constants, instruction field layout and decode helpers for the operand_fetch stage.
// Optional EX/MEM bypassing is selected with the OPERAND_FETCH_FORWARD_EN macro.
package operand_fetch_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;

  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b1;

  localparam logic [5:0] OPC_LOAD = 6'h02;
  localparam logic [5:0] OPC_NOP  = 6'h00;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RA_MSB   = 25;
  localparam int RA_LSB   = 21;
  localparam int RB_MSB   = 20;
  localparam int RB_LSB   = 16;
  localparam int RC_MSB   = 15;
  localparam int RC_LSB   = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int FORM_BIT = 5;

  typedef struct packed {
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] rc;
    logic [15:0]           imm;
  } insn_fields_t;

  function automatic insn_fields_t split_insn(input logic [WORD_DATA_W-1:0] insn);
    insn_fields_t f;
    f.opcode = insn[OPC_MSB:OPC_LSB];
    f.ra     = insn[RA_MSB:RA_LSB];
    f.rb     = insn[RB_MSB:RB_LSB];
    f.rc     = insn[RC_MSB:RC_LSB];
    f.imm    = insn[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  function automatic logic [WORD_DATA_W-1:0] sign_ext16(input logic [15:0] v);
    return {{(WORD_DATA_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-source operand selector: picks EX, MEM or gpr data and flags when the source cannot be read yet.
// With OPERAND_FETCH_FORWARD_EN undefined, any pending EX/MEM write to the source requests a stall.
module fwd_mux
  import operand_fetch_pkg::*;
(
  input  logic [REG_ADDR_W-1:0]  src,
  input  logic [WORD_DATA_W-1:0] gpr_data,
  input  logic                   ex_we_,
  input  logic [REG_ADDR_W-1:0]  ex_dst,
  input  logic [WORD_DATA_W-1:0] ex_data,
  input  logic                   ex_is_load,
  input  logic                   mem_we_,
  input  logic [REG_ADDR_W-1:0]  mem_dst,
  input  logic [WORD_DATA_W-1:0] mem_data,
  output logic [WORD_DATA_W-1:0] data,
  output logic                   stall_req
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = (ex_we_ == ENABLE_) && (ex_dst == src);
  assign mem_hit = (mem_we_ == ENABLE_) && (mem_dst == src);

`ifdef OPERAND_FETCH_FORWARD_EN
  // A load in EX has no data yet, so it falls through and the hazard logic bubbles instead.
  always_comb begin
    data = gpr_data;
    if (ex_hit && !ex_is_load)
      data = ex_data;
    else if (mem_hit)
      data = mem_data;
  end

  assign stall_req = ex_hit && ex_is_load;
`else
  logic unused_fwd;

  assign unused_fwd = ^{ex_data, mem_data, ex_is_load};
  assign data       = gpr_data;
  assign stall_req  = ex_hit || mem_hit;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: splits the instruction, reads gpr, resolves operands and fills ID/EX.
// Define OPERAND_FETCH_FORWARD_EN to bypass EX/MEM results; otherwise pending writes cause bubbles.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   if_en,
  input  logic [WORD_DATA_W-1:0] if_pc,
  input  logic [WORD_DATA_W-1:0] if_insn,
  input  logic                   stall,
  input  logic                   flush,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr0,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr1,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data0,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data1,
  input  logic                   ex_we_,
  input  logic [REG_ADDR_W-1:0]  ex_dst,
  input  logic [WORD_DATA_W-1:0] ex_data,
  input  logic                   ex_is_load,
  input  logic                   mem_we_,
  input  logic [REG_ADDR_W-1:0]  mem_dst,
  input  logic [WORD_DATA_W-1:0] mem_data,
  output logic                   hazard_stall,
  output logic                   id_en,
  output logic [WORD_DATA_W-1:0] id_pc,
  output logic [5:0]             id_opcode,
  output logic [REG_ADDR_W-1:0]  id_dst,
  output logic                   id_we_,
  output logic [WORD_DATA_W-1:0] id_op_a,
  output logic [WORD_DATA_W-1:0] id_op_b
);

  insn_fields_t           f;
  logic                   i_form;
  logic                   we_dec;
  logic                   hazard;
  logic                   stall_a;
  logic                   stall_b;
  logic [WORD_DATA_W-1:0] fwd_a;
  logic [WORD_DATA_W-1:0] fwd_b;
  logic [WORD_DATA_W-1:0] op_b;
  logic [REG_ADDR_W-1:0]  dst;

  assign f            = split_insn(if_insn);
  assign i_form       = f.opcode[FORM_BIT];
  assign gpr_rd_addr0 = f.ra;
  assign gpr_rd_addr1 = f.rb;

  fwd_mux u_fwd_a (
    .src        (f.ra),
    .gpr_data   (gpr_rd_data0),
    .ex_we_     (ex_we_),
    .ex_dst     (ex_dst),
    .ex_data    (ex_data),
    .ex_is_load (ex_is_load),
    .mem_we_    (mem_we_),
    .mem_dst    (mem_dst),
    .mem_data   (mem_data),
    .data       (fwd_a),
    .stall_req  (stall_a)
  );

  fwd_mux u_fwd_b (
    .src        (f.rb),
    .gpr_data   (gpr_rd_data1),
    .ex_we_     (ex_we_),
    .ex_dst     (ex_dst),
    .ex_data    (ex_data),
    .ex_is_load (ex_is_load),
    .mem_we_    (mem_we_),
    .mem_dst    (mem_dst),
    .mem_data   (mem_data),
    .data       (fwd_b),
    .stall_req  (stall_b)
  );

  // In I-form rb is the destination, so it must not trigger a hazard.
  assign op_b         = i_form ? sign_ext16(f.imm) : fwd_b;
  assign dst          = i_form ? f.rb : f.rc;
  assign we_dec       = (f.opcode == OPC_NOP) ? DISABLE_ : ENABLE_;
  assign hazard       = if_en && (stall_a || (!i_form && stall_b));
  assign hazard_stall = hazard && !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset_ == RESET_ENABLE) begin
      id_en     <= 1'b0;
      id_pc     <= '0;
      id_opcode <= '0;
      id_dst    <= '0;
      id_we_    <= DISABLE_;
      id_op_a   <= '0;
      id_op_b   <= '0;
    end else if (flush) begin
      id_en  <= 1'b0;
      id_we_ <= DISABLE_;
    end else if (stall) begin
      id_en  <= id_en;
    end else if (hazard) begin
      id_en  <= 1'b0;
      id_we_ <= DISABLE_;
    end else begin
      id_en     <= if_en;
      id_pc     <= if_pc;
      id_opcode <= f.opcode;
      id_dst    <= dst;
      id_we_    <= if_en ? we_dec : DISABLE_;
      id_op_a   <= fwd_a;
      id_op_b   <= op_b;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed cases then random traffic against a register-level model.
// The model follows OPERAND_FETCH_FORWARD_EN the same way the design does.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_, if_en, stall, flush;
  logic [31:0] if_pc, if_insn, gpr_rd_data0, gpr_rd_data1;
  logic [4:0]  gpr_rd_addr0, gpr_rd_addr1;
  logic        ex_we_, ex_is_load, mem_we_;
  logic [4:0]  ex_dst, mem_dst;
  logic [31:0] ex_data, mem_data;
  logic        hazard_stall, id_en, id_we_;
  logic [31:0] id_pc, id_op_a, id_op_b;
  logic [5:0]  id_opcode;
  logic [4:0]  id_dst;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset_(reset_), .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn),
    .stall(stall), .flush(flush),
    .gpr_rd_addr0(gpr_rd_addr0), .gpr_rd_addr1(gpr_rd_addr1),
    .gpr_rd_data0(gpr_rd_data0), .gpr_rd_data1(gpr_rd_data1),
    .ex_we_(ex_we_), .ex_dst(ex_dst), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_we_(mem_we_), .mem_dst(mem_dst), .mem_data(mem_data),
    .hazard_stall(hazard_stall), .id_en(id_en), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_dst(id_dst), .id_we_(id_we_), .id_op_a(id_op_a), .id_op_b(id_op_b)
  );

  typedef struct packed {
    logic        rst, en;
    logic [31:0] pc, insn;
    logic        stl, fl;
    logic [31:0] g0, g1;
    logic        ex_we, ex_ld;
    logic [4:0]  ex_dst;
    logic [31:0] ex_data;
    logic        mem_we;
    logic [4:0]  mem_dst;
    logic [31:0] mem_data;
  } stim_t;

  typedef struct packed {
    logic        hs;
    logic [4:0]  a0, a1;
    logic        en, we;
    logic [31:0] pc;
    logic [5:0]  opc;
    logic [4:0]  dst;
    logic [31:0] op_a, op_b;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mdl = '0;
  int    compared = 0;
  int    mismatched = 0;
  stim_t s;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] opc, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [4:0] rc);
    return {opc, ra, rb, rc, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [15:0] imm);
    return {opc, ra, rb, imm};
  endfunction

  function automatic stim_t quiet();
    stim_t q;
    q = '0;
    q.en = 1'b1;
    q.pc = $urandom;
    q.insn = mk_r(6'h01, 5'd1, 5'd2, 5'd3);
    q.g0 = $urandom;
    q.g1 = $urandom;
    q.ex_we = 1'b1;
    q.ex_data = $urandom;
    q.mem_we = 1'b1;
    q.mem_data = $urandom;
    return q;
  endfunction

  // Walks the producers youngest-first; "blocked" means the value cannot be read this cycle.
  function automatic void resolve(input stim_t st, input logic [4:0] src, input logic [31:0] gpr,
                                  output logic blocked, output logic [31:0] val);
    logic        we[2];
    logic [4:0]  dd[2];
    logic [31:0] dv[2];
    blocked = 1'b0;
    val = gpr;
    we[0] = st.ex_we;  dd[0] = st.ex_dst;  dv[0] = st.ex_data;
    we[1] = st.mem_we; dd[1] = st.mem_dst; dv[1] = st.mem_data;
    for (int i = 0; i < 2; i++) begin
      if (we[i] == 1'b0 && dd[i] == src) begin
`ifdef OPERAND_FETCH_FORWARD_EN
        if (i == 0 && st.ex_ld) blocked = 1'b1;
        else val = dv[i];
`else
        blocked = 1'b1;
`endif
        return;
      end
    end
  endfunction

  task automatic applyStimulus(input stim_t st);
    exp_t        e;
    logic [5:0]  opc;
    logic [4:0]  ra, rb, rc;
    logic        iform, ba, bb, haz;
    logic [31:0] va, vb;
    @(negedge clk);
    reset_ = st.rst; if_en = st.en; if_pc = st.pc; if_insn = st.insn;
    stall = st.stl; flush = st.fl; gpr_rd_data0 = st.g0; gpr_rd_data1 = st.g1;
    ex_we_ = st.ex_we; ex_is_load = st.ex_ld; ex_dst = st.ex_dst; ex_data = st.ex_data;
    mem_we_ = st.mem_we; mem_dst = st.mem_dst; mem_data = st.mem_data;
    opc = st.insn[31:26]; ra = st.insn[25:21]; rb = st.insn[20:16]; rc = st.insn[15:11];
    iform = opc[5];
    resolve(st, ra, st.g0, ba, va);
    resolve(st, rb, st.g1, bb, vb);
    haz = st.en && (ba || (!iform && bb));
    if (st.rst) begin
      mdl = '0;
      mdl.we = 1'b1;
    end else if (st.fl || (!st.stl && haz)) begin
      mdl.en = 1'b0;
      mdl.we = 1'b1;
    end else if (!st.stl) begin
      mdl.en = st.en;
      mdl.pc = st.pc;
      mdl.opc = opc;
      mdl.dst = iform ? rb : rc;
      mdl.we = st.en ? (opc == 6'h00) : 1'b1;
      mdl.op_a = va;
      mdl.op_b = iform ? 32'($signed(st.insn[15:0])) : vb;
    end
    e = mdl;
    e.hs = haz && !st.fl && !st.stl;
    e.a0 = ra;
    e.a1 = rb;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a fresh ID/EX state and hazard decision.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hazard_stall", hazard_stall, e.hs);
        checkOutput("gpr_rd_addr0", gpr_rd_addr0, e.a0);
        checkOutput("gpr_rd_addr1", gpr_rd_addr1, e.a1);
        checkOutput("id_en", id_en, e.en);
        checkOutput("id_we_", id_we_, e.we);
        checkOutput("id_pc", id_pc, e.pc);
        checkOutput("id_opcode", id_opcode, e.opc);
        checkOutput("id_dst", id_dst, e.dst);
        checkOutput("id_op_a", id_op_a, e.op_a);
        checkOutput("id_op_b", id_op_b, e.op_b);
      end
    end
  end

  initial begin
    reset_ = 1'b1; if_en = 1'b0; if_pc = '0; if_insn = '0; stall = 1'b0; flush = 1'b0;
    gpr_rd_data0 = '0; gpr_rd_data1 = '0; ex_we_ = 1'b1; ex_is_load = 1'b0; ex_dst = '0;
    ex_data = '0; mem_we_ = 1'b1; mem_dst = '0; mem_data = '0;

    s = quiet(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = quiet(); s.pc = 32'h100;
    applyStimulus(s);

    s = quiet(); s.insn = mk_r(6'h01, 5'd3, 5'd4, 5'd6); s.g0 = 32'hFF; s.g1 = 32'hFF;
    s.ex_we = 1'b0; s.ex_dst = 5'd3; s.ex_data = 32'h11;
    s.mem_we = 1'b0; s.mem_dst = 5'd4; s.mem_data = 32'h22;
    applyStimulus(s);

    s = quiet(); s.insn = mk_r(6'h01, 5'd5, 5'd5, 5'd8);
    s.ex_we = 1'b0; s.ex_dst = 5'd5; s.ex_data = 32'hAA;
    s.mem_we = 1'b0; s.mem_dst = 5'd5; s.mem_data = 32'hBB;
    applyStimulus(s);

    s = quiet(); s.insn = mk_r(6'h01, 5'd7, 5'd2, 5'd10);
    s.ex_we = 1'b0; s.ex_ld = 1'b1; s.ex_dst = 5'd7;
    applyStimulus(s);
    s.ex_we = 1'b1; s.ex_ld = 1'b0; s.mem_we = 1'b0; s.mem_dst = 5'd7; s.mem_data = 32'h1234;
    applyStimulus(s);
    s.mem_we = 1'b1; s.g0 = 32'h1234;
    applyStimulus(s);

    s = quiet(); s.insn = mk_i(6'h21, 5'd1, 5'd9, 16'hFFF0);
    s.ex_we = 1'b0; s.ex_ld = 1'b1; s.ex_dst = 5'd9;
    applyStimulus(s);

    s = quiet();
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = quiet(); s.stl = 1'b1; s.insn = $urandom;
      applyStimulus(s);
    end
    s.fl = 1'b1;
    applyStimulus(s);
    s = quiet();
    applyStimulus(s);

    s = quiet(); s.stl = 1'b1; s.rst = 1'b1;
    applyStimulus(s);
    s = quiet();
    applyStimulus(s);
    s = quiet(); s.insn = 32'h0000_1234;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s = quiet();
      s.rst = ($urandom_range(0, 49) == 0);
      s.en = ($urandom_range(0, 3) != 0);
      s.stl = ($urandom_range(0, 7) == 0);
      s.fl = ($urandom_range(0, 9) == 0);
      s.insn = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
      s.ex_we = 1'($urandom_range(0, 1));
      s.ex_ld = ($urandom_range(0, 2) == 0);
      s.ex_dst = 5'($urandom_range(0, 7));
      s.mem_we = 1'($urandom_range(0, 1));
      s.mem_dst = 5'($urandom_range(0, 7));
      applyStimulus(s);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) checkOutput("scoreboard_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
